// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operation encoding, chunk sizing helper
// and the elaboration-time divisibility check used by pipelined adders.
`ifndef ALU_PKG_SV
`define ALU_PKG_SV

package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_t;

    // Width of one pipeline chunk when WIDTH bits are split over STAGES stages.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// Stops elaboration when the operand width cannot be split into equal chunks.
`define ALU_CHECK_DIVISIBLE(W, S) \
    if (((W) % (S)) != 0) begin : g_width_stage_check \
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES"); \
    end

`endif

// File: rtl/add_sub_stage.sv
// One slice of the pipelined adder/subtractor: a CHUNK-bit ripple adder
// working on chunk IDX of the operands, followed by the stage register that
// carries valid, operands, partial result, mode and carries to the next slice.
module add_sub_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_sub,
    input  logic             in_carry,
    input  logic             down_adv,
    output logic             adv,
    output logic             vld_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] res_q,
    output logic             sub_q,
    output logic             carry_q,
    output logic             msb_q
);

    addsub_op_t       op;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK-1:0] sum;
    logic [CHUNK:0]   c;

    logic             vld_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic             sub_d;
    logic             carry_d;
    logic             msb_d;

    // Ripple-carry over this chunk; subtraction inverts b and relies on the
    // carry-in of chunk 0 being the sub bit.
    always_comb begin
        op      = in_sub ? OP_SUB : OP_ADD;
        a_chunk = in_a[IDX*CHUNK +: CHUNK];
        b_eff   = (op == OP_SUB) ? ~in_b[IDX*CHUNK +: CHUNK] : in_b[IDX*CHUNK +: CHUNK];
        sum     = '0;
        c       = '0;
        c[0]    = in_carry;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a_chunk[i] ^ b_eff[i] ^ c[i];
            c[i+1]   = (a_chunk[i] & b_eff[i]) | (c[i] & (a_chunk[i] ^ b_eff[i]));
        end
    end

    // Next register contents: operands and mode travel unchanged, this
    // chunk's sum is merged into the partial result, carries are captured.
    always_comb begin
        vld_d   = in_vld;
        a_d     = in_a;
        b_d     = in_b;
        sub_d   = in_sub;
        carry_d = c[CHUNK];
        msb_d   = c[CHUNK-1];
        res_d   = in_res;
        res_d[IDX*CHUNK +: CHUNK] = sum;
    end

    // The slice moves on when it is empty or its downstream side is moving.
    always_comb begin
        adv = !vld_q || down_adv;
    end

    // Stage register; holds everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            msb_q   <= 1'b0;
        end else if (adv) begin
            vld_q   <= vld_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            msb_q   <= msb_d;
        end
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor. WIDTH is split into STAGES chunks,
// one chunk resolved per clock with the carry registered between slices.
// valid/ready handshake with full back-pressure; in_ready is combinational
// from out_ready through the advance chain so a full pipe never bubbles.
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    `ALU_CHECK_DIVISIBLE(WIDTH, STAGES)

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] sub_s;
    logic [STAGES-1:0] carry_s;
    logic [STAGES-1:0] msb_s;
    logic [STAGES-1:0] in_vld_s;
    logic [STAGES-1:0] in_sub_s;
    logic [STAGES-1:0] in_carry_s;
    logic [STAGES-1:0] down_adv_s;
    logic [WIDTH-1:0]  a_s      [STAGES];
    logic [WIDTH-1:0]  b_s      [STAGES];
    logic [WIDTH-1:0]  res_s    [STAGES];
    logic [WIDTH-1:0]  in_a_s   [STAGES];
    logic [WIDTH-1:0]  in_b_s   [STAGES];
    logic [WIDTH-1:0]  in_res_s [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // First slice takes the live operands; carry-in is the sub bit.
            assign in_vld_s[k]   = in_valid;
            assign in_a_s[k]     = a;
            assign in_b_s[k]     = b;
            assign in_sub_s[k]   = sub;
            assign in_carry_s[k] = sub;
            assign in_res_s[k]   = '0;
        end else begin : g_body
            // Later slices take the skewed operands and carry of the previous slice.
            assign in_vld_s[k]   = vld_s[k-1];
            assign in_a_s[k]     = a_s[k-1];
            assign in_b_s[k]     = b_s[k-1];
            assign in_sub_s[k]   = sub_s[k-1];
            assign in_carry_s[k] = carry_s[k-1];
            assign in_res_s[k]   = res_s[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_adv_s[k] = out_ready;
        end else begin : g_mid
            assign down_adv_s[k] = adv_s[k+1];
        end

        add_sub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (in_vld_s[k]),
            .in_a     (in_a_s[k]),
            .in_b     (in_b_s[k]),
            .in_res   (in_res_s[k]),
            .in_sub   (in_sub_s[k]),
            .in_carry (in_carry_s[k]),
            .down_adv (down_adv_s[k]),
            .adv      (adv_s[k]),
            .vld_q    (vld_s[k]),
            .a_q      (a_s[k]),
            .b_q      (b_s[k]),
            .res_q    (res_s[k]),
            .sub_q    (sub_s[k]),
            .carry_q  (carry_s[k]),
            .msb_q    (msb_s[k])
        );
    end

    assign in_ready  = adv_s[0];
    assign out_valid = vld_s[STAGES-1];
    assign result    = res_s[STAGES-1];
    assign carry_out = carry_s[STAGES-1];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign overflow  = msb_s[STAGES-1] ^ carry_s[STAGES-1];

    // The last slice's operand copies and the inner MSB carries have no consumer.
    logic unused_tail;
    assign unused_tail = ^{a_s[STAGES-1], b_s[STAGES-1], sub_s, msb_s};

endmodule
